sensor_poll_scheduler: RTL
==========================

Name: sensor_poll_scheduler

Overview:
Sequences the two pet sensors, the ultrasonic ranger and the MPU6050 I2C reader, so they never run at once. The ranging runs first and the IMU read second. Each poll cycle starts on a periodic timer or on a forced request from the test button. The block latches both results, flags timeouts and I2C errors, and gives the pet FSM one coherent snapshot per cycle with a single-cycle valid strobe.

Parameters:
POLL_PERIOD, 5000000, clk cycles between automatic poll cycles (100 ms at 50 MHz)
US_TIMEOUT, 1500000, max cycles in US_WAIT before declaring an ultrasonic fault
IMU_TIMEOUT, 500000, max cycles in IMU_WAIT before declaring an IMU fault
DATA_W, 16, width of distance and acceleration words

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable_i  in  1  allows periodic polling; when low, the period counter freezes
force_i  in  1  single-cycle request for an immediate poll cycle (debounced test button)
us_start_o  out  1  single-cycle start pulse to the ultrasonic counter
us_done_i  in  1  ranging complete; us_dist_i valid in the same cycle
us_dist_i  in  DATA_W  measured distance
imu_start_o  out  1  single-cycle start pulse to the MPU6050 reader
imu_done_i  in  1  I2C transaction complete
imu_err_i  in  1  NACK/error, qualified by imu_done_i
imu_accel_i  in  DATA_W  acceleration sample, qualified by imu_done_i
dist_o  out  DATA_W  latched distance
accel_o  out  DATA_W  latched acceleration
sample_valid_o  out  1  single-cycle strobe; snapshot updated
us_fault_o  out  1  last ranging timed out
imu_fault_o  out  1  last IMU read timed out or errored
busy_o  out  1  high in every state except IDLE
state_o  out  3  encoded state for debug LEDs

Behaviour:
- Reset (rst=0, async):
  - state IDLE.
  - All outputs 0.
  - Period counter loaded with POLL_PERIOD-1.
  - Force-pending flag cleared.
  - An in-flight cycle is abandoned; start pulses never extend past reset.
- Encoding: IDLE=0, US_TRIG=1, US_WAIT=2, IMU_TRIG=3, IMU_WAIT=4, PUBLISH=5.
- Period counter:
  - Decrements each cycle while enable_i=1 and state=IDLE.
  - Holds its value in all other conditions.
  - Reloads to POLL_PERIOD-1 whenever IDLE leaves for US_TRIG.
- IDLE -> US_TRIG when the counter is 0 with enable_i=1, or force_i=1, or force-pending=1.
  - force_i is honoured regardless of enable_i.
  - Going to US_TRIG clears force-pending.
- force_i in any non-IDLE state sets force-pending; multiple requests collapse into one.
- US_TRIG: us_start_o=1 for exactly this cycle; next state US_WAIT; timeout counter cleared.
  - Latency from trigger condition in IDLE to us_start_o = 1 cycle.
- US_WAIT:
  - us_done_i=1: dist_o<=us_dist_i, us_fault_o<=0, go to IMU_TRIG.
  - Timeout counter reaches US_TIMEOUT-1 without done: dist_o<=all ones (out of range), us_fault_o<=1, go to IMU_TRIG.
  - done and expiry in the same cycle: done wins.
- IMU_TRIG: imu_start_o=1 for one cycle; next state IMU_WAIT; timeout counter cleared.
- IMU_WAIT:
  - imu_done_i=1 with imu_err_i=0: accel_o<=imu_accel_i, imu_fault_o<=0.
  - imu_done_i=1 with imu_err_i=1: accel_o holds, imu_fault_o<=1.
  - Timeout at IMU_TIMEOUT-1: accel_o holds, imu_fault_o<=1.
  - Any of the three goes to PUBLISH; done wins over expiry.
- PUBLISH: sample_valid_o=1 for one cycle; next state IDLE.
  - If force-pending is set, IDLE goes straight to US_TRIG on the following cycle.
- Done inputs: us_done_i outside US_WAIT and imu_done_i outside IMU_WAIT are ignored.
- enable_i dropping mid-cycle does not abort the cycle; it completes through PUBLISH.
- Faults are sticky until the next completion of the same sensor.
- dist_o, accel_o and the fault flags change only in the WAIT states; they stay stable from one PUBLISH to the next.

Test Plan:
1. Bench parameters POLL_PERIOD=100, US_TIMEOUT=20, IMU_TIMEOUT=10. Release reset, enable_i=1 -> us_start_o pulses exactly 100 cycles after reset release.
2. Respond us_done_i with us_dist_i=0x0123 after 5 cycles and imu_done_i with imu_accel_i=0x0F0F after 3 cycles -> sample_valid_o pulses once, dist_o=0x0123, accel_o=0x0F0F, both faults 0.
3. Never assert us_done_i -> IMU_TRIG is entered 20 cycles after US_WAIT entry, dist_o=0xFFFF, us_fault_o=1; the IMU still runs and the cycle publishes.
4. Answer imu_done_i with imu_err_i=1 and a new accel -> accel_o keeps the previous 0x0F0F, imu_fault_o=1. Next cycle answers cleanly -> imu_fault_o returns to 0.
5. Pulse force_i in IDLE with enable_i=0 -> us_start_o next cycle. Pulse force_i twice during US_WAIT -> exactly one extra cycle starts the cycle after PUBLISH.
6. Assert rst=0 mid IMU_WAIT -> all outputs 0 immediately; a late imu_done_i is ignored; periodic polling restarts 100 cycles after reset release.

Source files
------------

// File: rtl/sensor_poll_scheduler.sv
// Poll sequencer for the ultrasonic ranger and MPU6050 reader: runs one sensor at a time,
// latches both results with fault flags and publishes one snapshot per poll cycle.
module sensor_poll_scheduler #(
    parameter int POLL_PERIOD = 5000000,
    parameter int US_TIMEOUT  = 1500000,
    parameter int IMU_TIMEOUT = 500000,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              force_i,
    output logic              us_start_o,
    input  logic              us_done_i,
    input  logic [DATA_W-1:0] us_dist_i,
    output logic              imu_start_o,
    input  logic              imu_done_i,
    input  logic              imu_err_i,
    input  logic [DATA_W-1:0] imu_accel_i,
    output logic [DATA_W-1:0] dist_o,
    output logic [DATA_W-1:0] accel_o,
    output logic              sample_valid_o,
    output logic              us_fault_o,
    output logic              imu_fault_o,
    output logic              busy_o,
    output logic [2:0]        state_o
);

    localparam int PCW  = $clog2(POLL_PERIOD);
    localparam int TMAX = (US_TIMEOUT > IMU_TIMEOUT) ? US_TIMEOUT : IMU_TIMEOUT;
    localparam int TW   = $clog2(TMAX);

    localparam logic [PCW-1:0] PERIOD_RELOAD = PCW'(POLL_PERIOD - 1);
    localparam logic [PCW-1:0] PCNT_ONE      = PCW'(1);
    localparam logic [TW-1:0]  US_LAST       = TW'(US_TIMEOUT - 1);
    localparam logic [TW-1:0]  IMU_LAST      = TW'(IMU_TIMEOUT - 1);
    localparam logic [TW-1:0]  TCNT_ONE      = TW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        US_TRIG  = 3'd1,
        US_WAIT  = 3'd2,
        IMU_TRIG = 3'd3,
        IMU_WAIT = 3'd4,
        PUBLISH  = 3'd5
    } state_t;

    state_t         state;
    logic [PCW-1:0] period_cnt;
    logic [TW-1:0]  timeout_cnt;
    logic           force_pending;
    logic           start_cycle;

    // A button press is honoured even while periodic polling is disabled.
    assign start_cycle = (enable_i && (period_cnt == '0)) || force_i || force_pending;
    assign busy_o      = (state != IDLE);
    assign state_o     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            period_cnt     <= PERIOD_RELOAD;
            timeout_cnt    <= '0;
            force_pending  <= 1'b0;
            us_start_o     <= 1'b0;
            imu_start_o    <= 1'b0;
            sample_valid_o <= 1'b0;
            dist_o         <= '0;
            accel_o        <= '0;
            us_fault_o     <= 1'b0;
            imu_fault_o    <= 1'b0;
        end else begin
            us_start_o     <= 1'b0;
            imu_start_o    <= 1'b0;
            sample_valid_o <= 1'b0;

            if ((state != IDLE) && force_i) begin
                force_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_cycle) begin
                        state         <= US_TRIG;
                        us_start_o    <= 1'b1;
                        period_cnt    <= PERIOD_RELOAD;
                        force_pending <= 1'b0;
                    end else if (enable_i) begin
                        period_cnt <= period_cnt - PCNT_ONE;
                    end
                end
                US_TRIG: begin
                    state       <= US_WAIT;
                    timeout_cnt <= '0;
                end
                US_WAIT: begin
                    // Completion is checked first so a done on the expiry cycle still counts.
                    if (us_done_i) begin
                        dist_o      <= us_dist_i;
                        us_fault_o  <= 1'b0;
                        state       <= IMU_TRIG;
                        imu_start_o <= 1'b1;
                    end else if (timeout_cnt == US_LAST) begin
                        dist_o      <= '1;
                        us_fault_o  <= 1'b1;
                        state       <= IMU_TRIG;
                        imu_start_o <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + TCNT_ONE;
                    end
                end
                IMU_TRIG: begin
                    state       <= IMU_WAIT;
                    timeout_cnt <= '0;
                end
                IMU_WAIT: begin
                    if (imu_done_i) begin
                        if (!imu_err_i) begin
                            accel_o     <= imu_accel_i;
                            imu_fault_o <= 1'b0;
                        end else begin
                            imu_fault_o <= 1'b1;
                        end
                        state          <= PUBLISH;
                        sample_valid_o <= 1'b1;
                    end else if (timeout_cnt == IMU_LAST) begin
                        imu_fault_o    <= 1'b1;
                        state          <= PUBLISH;
                        sample_valid_o <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + TCNT_ONE;
                    end
                end
                PUBLISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
